// File: rtl/alu_issue_stage.sv
// Issue stage for the 4-bit ALU: buffers packed commands, drives operands, holds them for a
// settle window, then registers the 8-bit result. Optional build macro: ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_cmd,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_result,
    output logic [3:0]  out_sel,
    output logic        busy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_e;

    state_e        state_q;
    logic [2:0]    settle_cnt_q;
    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          handshake;
    logic [11:0]   head;

    assign fifo_empty = (count_q == '0);
    // No pass-through when full: a same-edge pop never opens a slot early.
    assign in_ready   = !rst && (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign head       = mem_q[rd_ptr_q];
    assign busy       = !rst && ((state_q != StIdle) || !fifo_empty);

    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StIdle:  pop = !fifo_empty;
            StHold:  pop = handshake && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= 3'd0;
            alu_a        <= 4'd0;
            alu_b        <= 4'd0;
            alu_sel      <= 4'd0;
            out_valid    <= 1'b0;
            out_result   <= 8'd0;
            out_sel      <= 4'd0;
`ifdef ALU_ISSUE_STATS_EN
            op_count     <= 16'd0;
`endif
        end else begin
`ifdef ALU_ISSUE_STATS_EN
            if (handshake) begin
                op_count <= op_count + 16'd1;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        alu_a        <= head[3:0];
                        alu_b        <= head[7:4];
                        alu_sel      <= head[11:8];
                        settle_cnt_q <= 3'(SETTLE_CYCLES);
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    settle_cnt_q <= settle_cnt_q - 3'd1;
                    // Last settle edge: alu_c has seen stable operands long enough.
                    if (settle_cnt_q == 3'd1) begin
                        out_result <= alu_c;
                        out_sel    <= alu_sel;
                        out_valid  <= 1'b1;
                        state_q    <= StHold;
                    end
                end
                StHold: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            alu_a        <= head[3:0];
                            alu_b        <= head[7:4];
                            alu_sel      <= head[11:8];
                            settle_cnt_q <= 3'(SETTLE_CYCLES);
                            state_q      <= StSettle;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: one instance with SETTLE_CYCLES=1, one with 3.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [11:0] in_cmd1;
    logic [3:0]  alu_a1, alu_b1, alu_sel1, out_sel1;
    logic [7:0]  alu_c1, out_result1;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [11:0] in_cmd3;
    logic [3:0]  alu_a3, alu_b3, alu_sel3, out_sel3;
    logic [7:0]  alu_c3, out_result3;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_count1, op_count3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in ALU: ADD, AND, MUL, 4-bit SUB; undefined codes yield 0.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] sel);
        logic [3:0] d;
        case (sel)
            4'h0:    return {4'h0, a} + {4'h0, b};
            4'h1:    return {4'h0, a & b};
            4'h5:    return {4'h0, a} * {4'h0, b};
            4'hF: begin
                d = a - b;
                return {4'h0, d};
            end
            default: return 8'h00;
        endcase
    endfunction

    assign alu_c1 = alu_model(alu_a1, alu_b1, alu_sel1);
    assign alu_c3 = alu_model(alu_a3, alu_b3, alu_sel3);

    alu_issue_stage #(.DEPTH(4), .SETTLE_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_cmd     (in_cmd1),
        .alu_a      (alu_a1),
        .alu_b      (alu_b1),
        .alu_sel    (alu_sel1),
        .alu_c      (alu_c1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .out_result (out_result1),
        .out_sel    (out_sel1),
        .busy       (busy1)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .op_count   (op_count1)
`endif
    );

    alu_issue_stage #(.DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_cmd     (in_cmd3),
        .alu_a      (alu_a3),
        .alu_b      (alu_b3),
        .alu_sel    (alu_sel3),
        .alu_c      (alu_c3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .out_result (out_result3),
        .out_sel    (out_sel3),
        .busy       (busy3)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .op_count   (op_count3)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_res [5];
    int         accepted;
    int         idx;
    logic       take;

    initial begin
        rst        = 1'b1;
        in_valid1  = 1'b0;
        in_cmd1    = 12'h000;
        out_ready1 = 1'b1;
        in_valid3  = 1'b0;
        in_cmd3    = 12'h000;
        out_ready3 = 1'b1;
        step();
        step();
        check("rst_in_ready", 16'(in_ready1), 16'h0);
        check("rst_busy", 16'(busy1), 16'h0);
        check("rst_alu_a", 16'(alu_a1), 16'h0);
        check("rst_out_valid", 16'(out_valid1), 16'h0);
        check("rst_out_result", 16'(out_result1), 16'h0);
        check("rst_in_ready3", 16'(in_ready3), 16'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 16'(in_ready1), 16'h1);

        // ADD 3+5 with SETTLE_CYCLES=1
        in_valid1 = 1'b1;
        in_cmd1   = 12'h053;
        step();
        in_valid1 = 1'b0;
        check("add_busy", 16'(busy1), 16'h1);
        check("add_no_early_valid", 16'(out_valid1), 16'h0);
        step();
        check("add_alu_a", 16'(alu_a1), 16'h3);
        check("add_alu_b", 16'(alu_b1), 16'h5);
        check("add_valid_k1", 16'(out_valid1), 16'h0);
        step();
        check("add_valid_k2", 16'(out_valid1), 16'h1);
        check("add_result", 16'(out_result1), 16'h08);
        check("add_sel", 16'(out_sel1), 16'h0);
        step();
        check("add_drained", 16'(out_valid1), 16'h0);
        check("add_idle", 16'(busy1), 16'h0);

        // MUL then SUB back to back
        in_valid1 = 1'b1;
        in_cmd1   = 12'h5FF;
        step();
        in_cmd1   = 12'hF10;
        step();
        in_valid1 = 1'b0;
        check("mul_alu_sel", 16'(alu_sel1), 16'h5);
        step();
        check("mul_valid", 16'(out_valid1), 16'h1);
        check("mul_result", 16'(out_result1), 16'hE1);
        check("mul_sel", 16'(out_sel1), 16'h5);
        step();
        check("sub_alu_sel", 16'(alu_sel1), 16'hF);
        check("sub_gap", 16'(out_valid1), 16'h0);
        step();
        check("sub_valid", 16'(out_valid1), 16'h1);
        check("sub_result", 16'(out_result1), 16'h0F);
        check("sub_sel", 16'(out_sel1), 16'hF);
`ifdef ALU_ISSUE_STATS_EN
        step();
        check("stats_three", op_count1, 16'd3);
`else
        step();
`endif
        check("sub_idle", 16'(busy1), 16'h0);

        // Stall: fill result register plus FIFO while downstream is blocked
        for (int i = 0; i < 5; i++) begin
            exp_res[i] = 8'(2 * i + 3);
        end
        out_ready1 = 1'b0;
        accepted   = 0;
        in_valid1  = 1'b1;
        in_cmd1    = {4'h0, 4'd2, 4'd1};
        for (int c = 0; c < 12; c++) begin
            take = in_ready1;
            step();
            if (take) begin
                accepted++;
                in_cmd1 = {4'h0, 4'(accepted + 2), 4'(accepted + 1)};
            end
        end
        in_valid1 = 1'b0;
        check("stall_accepted", 16'(accepted), 16'd5);
        check("stall_in_ready", 16'(in_ready1), 16'h0);
        check("stall_busy", 16'(busy1), 16'h1);
        check("stall_valid", 16'(out_valid1), 16'h1);
        check("stall_frozen", 16'(out_result1), 16'(exp_res[0]));
        out_ready1 = 1'b1;
        step();
        check("drain_hs0", 16'(out_valid1), 16'h0);
        for (int j = 1; j < 5; j++) begin
            step();
            check("drain_valid", 16'(out_valid1), 16'h1);
            check("drain_result", 16'(out_result1), 16'(exp_res[j]));
            step();
            check("drain_gap", 16'(out_valid1), 16'h0);
        end
        check("drain_idle", 16'(busy1), 16'h0);
        check("drain_in_ready", 16'(in_ready1), 16'h1);
`ifdef ALU_ISSUE_STATS_EN
        check("stats_eight", op_count1, 16'd8);
`endif

        // AND with SETTLE_CYCLES=3
        in_valid3 = 1'b1;
        in_cmd3   = 12'h1CA;
        step();
        in_valid3 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            check("and_alu_a", 16'(alu_a3), 16'hA);
            check("and_alu_b", 16'(alu_b3), 16'hC);
            check("and_alu_sel", 16'(alu_sel3), 16'h1);
            check("and_not_yet", 16'(out_valid3), 16'h0);
        end
        step();
        check("and_valid", 16'(out_valid3), 16'h1);
        check("and_result", 16'(out_result3), 16'h08);
        check("and_sel", 16'(out_sel3), 16'h1);
        step();
        check("and_drained", 16'(out_valid3), 16'h0);

        // Reset mid-settle with two commands queued
        in_valid3 = 1'b1;
        in_cmd3   = 12'h012;
        step();
        in_cmd3   = 12'h034;
        step();
        in_cmd3   = 12'h056;
        step();
        in_valid3 = 1'b0;
        check("pre_rst_busy", 16'(busy3), 16'h1);
        check("pre_rst_alu_a", 16'(alu_a3), 16'h2);
        rst = 1'b1;
        #1;
        check("rst_hi_in_ready", 16'(in_ready3), 16'h0);
        check("rst_hi_busy", 16'(busy3), 16'h0);
        step();
        rst = 1'b0;
        check("mid_rst_alu_a", 16'(alu_a3), 16'h0);
        check("mid_rst_alu_b", 16'(alu_b3), 16'h0);
        check("mid_rst_alu_sel", 16'(alu_sel3), 16'h0);
        check("mid_rst_out_valid", 16'(out_valid3), 16'h0);
        check("mid_rst_out_result", 16'(out_result3), 16'h0);
        check("mid_rst_out_sel", 16'(out_sel3), 16'h0);
        check("mid_rst_busy", 16'(busy3), 16'h0);
`ifdef ALU_ISSUE_STATS_EN
        check("stats_reset", op_count1, 16'd0);
`endif
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid3 !== 1'b0) begin
                idx++;
            end
        end
        check("discarded_no_result", 16'(idx), 16'd0);
        check("discarded_idle", 16'(busy3), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
